// File: rtl/qdr_multiport_arbiter.sv
// Round-robin burst arbiter sharing one QDR controller between NUM_PORTS fabric ports and a backdoor,
// with a read-tag FIFO for return routing. Define QDR_ARB_STATS_EN to build the arb_stall_cnt statistic.
module qdr_multiport_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int QDR_ADDR_WIDTH = 21,
  parameter int QDR_DATA_WIDTH = 36,
  parameter int QDR_BW_WIDTH   = 2,
  parameter int MAX_BURST      = 16,
  parameter int TAG_AW         = 4
) (
  input  logic                                      qdr_clk,
  input  logic                                      qdr_rst_n,
  input  logic [NUM_PORTS*32-1:0]                   slave_addr,
  input  logic [NUM_PORTS-1:0]                      slave_wr_strb,
  input  logic [NUM_PORTS*2*QDR_DATA_WIDTH-1:0]     slave_wr_data,
  input  logic [NUM_PORTS*2*QDR_BW_WIDTH-1:0]       slave_wr_be,
  input  logic [NUM_PORTS-1:0]                      slave_rd_strb,
  output logic [NUM_PORTS-1:0]                      slave_ack,
  output logic [2*QDR_DATA_WIDTH-1:0]               slave_rd_data,
  output logic [NUM_PORTS-1:0]                      slave_rd_dvld,
  input  logic                                      disable_fabric,
  input  logic                                      backdoor_req,
  input  logic                                      backdoor_r,
  input  logic                                      backdoor_w,
  input  logic [31:0]                               backdoor_addr,
  input  logic [2*QDR_DATA_WIDTH-1:0]               backdoor_d,
  input  logic [2*QDR_BW_WIDTH-1:0]                 backdoor_be,
  output logic                                      backdoor_ack,
  output logic [2*QDR_DATA_WIDTH-1:0]               backdoor_q,
  output logic                                      backdoor_qvld,
  output logic [QDR_ADDR_WIDTH-1:0]                 master_addr,
  output logic                                      master_wr_strb,
  output logic                                      master_rd_strb,
  output logic [2*QDR_DATA_WIDTH-1:0]               master_wr_data,
  output logic [2*QDR_BW_WIDTH-1:0]                 master_wr_be,
  input  logic [2*QDR_DATA_WIDTH-1:0]               master_rd_data,
  input  logic                                      master_rd_dvld,
  output logic                                      tag_err,
  output logic [31:0]                               arb_stall_cnt
);
  localparam int D     = 2*QDR_DATA_WIDTH;
  localparam int B     = 2*QDR_BW_WIDTH;
  localparam int A     = QDR_ADDR_WIDTH;
  localparam int OW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW    = $clog2(NUM_PORTS+1);
  localparam int BCW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int DEPTH = 1 << TAG_AW;

  typedef enum logic [1:0] {PORT, BD, BD_WAIT} arb_state_t;

  arb_state_t        arb_state, arb_state_nxt;
  logic [OW-1:0]     owner, owner_nxt;
  logic [BCW-1:0]    burst, burst_nxt;

  logic [TW-1:0]     tag_mem [DEPTH];
  logic [TAG_AW-1:0] wr_ptr, rd_ptr;
  logic [TAG_AW:0]   count;
  logic              full, empty, push, pop;
  logic [TW-1:0]     head, push_tag;

  logic [NUM_PORTS-1:0] req, ack;
  logic              port_slot, owner_req, owner_wr, owner_rd;
  logic [A-1:0]      owner_addr;
  logic [D-1:0]      owner_data;
  logic [B-1:0]      owner_be;
  logic              other_found;
  logic [OW-1:0]     next_other;
  logic              unused_addr_bits;

  assign req   = (slave_wr_strb & {NUM_PORTS{~disable_fabric}}) | slave_rd_strb;
  assign full  = count[TAG_AW];
  assign empty = (count == '0);

  always_comb begin
    owner_addr = '0;
    owner_data = '0;
    owner_be   = '0;
    owner_wr   = 1'b0;
    owner_rd   = 1'b0;
    owner_req  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (owner == OW'(i)) begin
        owner_addr = slave_addr[i*32 +: A];
        owner_data = slave_wr_data[i*D +: D];
        owner_be   = slave_wr_be[i*B +: B];
        owner_wr   = slave_wr_strb[i] & ~disable_fabric;
        owner_rd   = slave_rd_strb[i];
        owner_req  = req[i];
      end
    end
  end

  // First requesting port strictly after the owner in circular order.
  always_comb begin
    other_found = 1'b0;
    next_other  = owner;
    for (int unsigned k = 1; k < NUM_PORTS; k++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!other_found && req[i] && (i == (32'(owner) + k) % NUM_PORTS)) begin
          other_found = 1'b1;
          next_other  = OW'(i);
        end
      end
    end
  end

  always_comb begin
    arb_state_nxt = arb_state;
    owner_nxt     = owner;
    burst_nxt     = burst;
    unique case (arb_state)
      PORT: begin
        if (backdoor_req && !full) begin
          arb_state_nxt = BD;
        end else if (other_found && (!owner_req || burst == BCW'(MAX_BURST-1))) begin
          owner_nxt = next_other;
          burst_nxt = '0;
        end else if (owner_req && !full && burst != BCW'(MAX_BURST-1)) begin
          burst_nxt = burst + 1'b1;
        end
      end
      BD: arb_state_nxt = BD_WAIT;
      BD_WAIT: begin
        arb_state_nxt = PORT;
        if (other_found) owner_nxt = next_other;
        burst_nxt = '0;
      end
      default: arb_state_nxt = PORT;
    endcase
  end

  // Reset gating keeps acks and strobes low while reset is held, whatever the inputs do.
  assign port_slot    = qdr_rst_n && (arb_state == PORT) && !full;
  assign backdoor_ack = qdr_rst_n && (arb_state == BD);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign ack[i]           = port_slot && (owner == OW'(i));
    assign slave_rd_dvld[i] = pop && (head == TW'(i));
  end
  assign slave_ack = ack;

  assign master_wr_strb = (owner_wr && port_slot) || (backdoor_w && backdoor_ack);
  assign master_rd_strb = (owner_rd && port_slot) || (backdoor_r && backdoor_ack);
  assign master_addr    = (arb_state == PORT) ? owner_addr : backdoor_addr[A-1:0];
  assign master_wr_data = (arb_state == PORT) ? owner_data : backdoor_d;
  assign master_wr_be   = (arb_state == PORT) ? owner_be   : backdoor_be;

  assign push     = master_rd_strb;
  assign push_tag = (arb_state == BD) ? TW'(NUM_PORTS) : TW'(owner);
  assign pop      = master_rd_dvld && !empty;
  assign head     = tag_mem[rd_ptr];

  assign backdoor_qvld = pop && (head == TW'(NUM_PORTS));
  assign slave_rd_data = master_rd_data;
  assign backdoor_q    = master_rd_data;

  assign unused_addr_bits = ^{backdoor_addr, slave_addr};

  always_ff @(posedge qdr_clk) begin
    if (push) tag_mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      arb_state <= PORT;
      owner     <= '0;
      burst     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tag_err   <= 1'b0;
    end else begin
      arb_state <= arb_state_nxt;
      owner     <= owner_nxt;
      burst     <= burst_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (master_rd_dvld && empty) tag_err <= 1'b1;
    end
  end

`ifdef QDR_ARB_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      stall_cnt <= '0;
    end else if (|req && !(|(req & ack)) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
  assign arb_stall_cnt = stall_cnt;
`else
  assign arb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_qdr_multiport_arbiter.sv
// Randomized bench for qdr_multiport_arbiter: a cycle-level reference model predicts acks and strobes,
// and a read-tag scoreboard queue is checked by an independent monitor on each returned read.
module tb_qdr_multiport_arbiter;
  localparam int P      = 2;
  localparam int DW     = 36;
  localparam int D      = 2*DW;
  localparam int BWW    = 2;
  localparam int B      = 2*BWW;
  localparam int A      = 21;
  localparam int MB     = 16;
  localparam int TAG_AW = 2;
  localparam int DEPTH  = 1 << TAG_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [P*32-1:0]   slave_addr;
  logic [P-1:0]      slave_wr_strb, slave_rd_strb, slave_ack, slave_rd_dvld;
  logic [P*D-1:0]    slave_wr_data;
  logic [P*B-1:0]    slave_wr_be;
  logic [D-1:0]      slave_rd_data, backdoor_d, backdoor_q, master_wr_data, master_rd_data;
  logic              disable_fabric, backdoor_req, backdoor_r, backdoor_w, backdoor_ack, backdoor_qvld;
  logic [31:0]       backdoor_addr, arb_stall_cnt;
  logic [B-1:0]      backdoor_be, master_wr_be;
  logic [A-1:0]      master_addr;
  logic              master_wr_strb, master_rd_strb, master_rd_dvld, tag_err;

  qdr_multiport_arbiter #(
    .NUM_PORTS(P), .QDR_ADDR_WIDTH(A), .QDR_DATA_WIDTH(DW),
    .QDR_BW_WIDTH(BWW), .MAX_BURST(MB), .TAG_AW(TAG_AW)
  ) dut (
    .qdr_clk(clk), .qdr_rst_n(rst_n),
    .slave_addr(slave_addr), .slave_wr_strb(slave_wr_strb), .slave_wr_data(slave_wr_data),
    .slave_wr_be(slave_wr_be), .slave_rd_strb(slave_rd_strb), .slave_ack(slave_ack),
    .slave_rd_data(slave_rd_data), .slave_rd_dvld(slave_rd_dvld), .disable_fabric(disable_fabric),
    .backdoor_req(backdoor_req), .backdoor_r(backdoor_r), .backdoor_w(backdoor_w),
    .backdoor_addr(backdoor_addr), .backdoor_d(backdoor_d), .backdoor_be(backdoor_be),
    .backdoor_ack(backdoor_ack), .backdoor_q(backdoor_q), .backdoor_qvld(backdoor_qvld),
    .master_addr(master_addr), .master_wr_strb(master_wr_strb), .master_rd_strb(master_rd_strb),
    .master_wr_data(master_wr_data), .master_wr_be(master_wr_be), .master_rd_data(master_rd_data),
    .master_rd_dvld(master_rd_dvld), .tag_err(tag_err), .arb_stall_cnt(arb_stall_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          q[$];
  int          m_state = 0;
  int          m_owner = 0;
  int          m_burst = 0;
  bit          exp_tag_err = 1'b0;
  int unsigned exp_stall = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_req(logic [P-1:0] r, int own);
    for (int k = 1; k < P; k++)
      if (r[(own + k) % P]) return (own + k) % P;
    return -1;
  endfunction

  // Modes: 0 both ports write, 1 port 1 writes with backdoor held, 2 random, 3 reads without returns,
  // 4 fabric disabled with port 0 writes, 5 stray return, 6 drain returns, other idle.
  task automatic drive(int mode);
    logic [95:0] r96;
    for (int i = 0; i < P; i++) begin
      slave_addr[i*32 +: 32] = $urandom;
      r96 = {$urandom, $urandom, $urandom};
      slave_wr_data[i*D +: D] = r96[D-1:0];
      slave_wr_be[i*B +: B] = B'($urandom);
    end
    backdoor_addr = $urandom;
    r96 = {$urandom, $urandom, $urandom};
    backdoor_d = r96[D-1:0];
    r96 = {$urandom, $urandom, $urandom};
    master_rd_data = r96[D-1:0];
    backdoor_be = B'($urandom);
    slave_wr_strb = '0; slave_rd_strb = '0; disable_fabric = 1'b0;
    backdoor_req = 1'b0; backdoor_w = 1'b0; backdoor_r = 1'b0; master_rd_dvld = 1'b0;
    case (mode)
      0: slave_wr_strb = '1;
      1: begin slave_wr_strb = 2'b10; backdoor_req = 1'b1; backdoor_w = 1'b1; end
      2, 3: begin
        slave_wr_strb  = (mode == 2) ? P'($urandom) : '0;
        slave_rd_strb  = P'($urandom);
        backdoor_req   = ($urandom_range(0, 3) == 0);
        backdoor_w     = (mode == 2) && $urandom_range(0, 1) == 1;
        backdoor_r     = !backdoor_w && (q.size() < DEPTH);
        master_rd_dvld = (mode == 2) && $urandom_range(0, 2) == 0;
        disable_fabric = ($urandom_range(0, 7) == 0);
      end
      4: begin disable_fabric = 1'b1; slave_wr_strb = 2'b01; end
      5, 6: master_rd_dvld = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cycle(int mode);
    logic [P-1:0] req, eack;
    logic [31:0]  oaddr;
    logic [D-1:0] odata;
    logic [B-1:0] obe;
    bit full, slot, bda, ewr, erd;
    int nxt;
    @(negedge clk);
    drive(mode);
    #2;
    full  = (q.size() >= DEPTH);
    req   = (slave_wr_strb & {P{!disable_fabric}}) | slave_rd_strb;
    slot  = (m_state == 0) && !full;
    bda   = (m_state == 1);
    eack  = '0;
    if (slot) eack[m_owner] = 1'b1;
    oaddr = slave_addr[m_owner*32 +: 32];
    odata = slave_wr_data[m_owner*D +: D];
    obe   = slave_wr_be[m_owner*B +: B];
    ewr   = (slot && slave_wr_strb[m_owner] && !disable_fabric) || (bda && backdoor_w);
    erd   = (slot && slave_rd_strb[m_owner]) || (bda && backdoor_r);
    check("slave_ack", slave_ack, eack);
    check("backdoor_ack", backdoor_ack, bda);
    check("master_wr_strb", master_wr_strb, ewr);
    check("master_rd_strb", master_rd_strb, erd);
    check("master_addr", master_addr, (m_state == 0) ? oaddr[A-1:0] : backdoor_addr[A-1:0]);
    check("master_wr_data", master_wr_data, (m_state == 0) ? odata : backdoor_d);
    check("master_wr_be", master_wr_be, (m_state == 0) ? obe : backdoor_be);
    check("arb_stall_cnt", arb_stall_cnt, exp_stall);
    nxt = next_req(req, m_owner);
    @(posedge clk);
    if (erd) q.push_back(bda ? P : m_owner);
`ifdef QDR_ARB_STATS_EN
    if (|req && !(|(req & eack)) && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
    case (m_state)
      0: begin
        if (backdoor_req && !full) m_state = 1;
        else if (nxt >= 0 && (!req[m_owner] || m_burst == MB-1)) begin
          m_owner = nxt;
          m_burst = 0;
        end else if (req[m_owner] && slot) m_burst = (m_burst + 1 > MB-1) ? MB-1 : m_burst + 1;
      end
      1: m_state = 2;
      default: begin
        m_state = 0;
        if (nxt >= 0) m_owner = nxt;
        m_burst = 0;
      end
    endcase
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_ack"}, slave_ack, 0);
    check({tag, "_bd_ack"}, backdoor_ack, 0);
    check({tag, "_wr_strb"}, master_wr_strb, 0);
    check({tag, "_rd_strb"}, master_rd_strb, 0);
    check({tag, "_dvld"}, {backdoor_qvld, slave_rd_dvld}, 0);
    check({tag, "_tag_err"}, tag_err, 0);
    check({tag, "_stall"}, arb_stall_cnt, 0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    drive(7);
    slave_wr_strb = '1; slave_rd_strb = '1;
    backdoor_req = 1'b1; backdoor_w = 1'b1; backdoor_r = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_quiet("mid_rst");
    q.delete();
    m_state = 0; m_owner = 0; m_burst = 0;
    exp_tag_err = 1'b0; exp_stall = 0;
    repeat (2) @(negedge clk);
    drive(7);
    rst_n = 1'b1;
  endtask

  // Read-return monitor: pops the expected tag whenever the controller returns data.
  initial begin
    logic [P:0] ev;
    int t;
    bit empty_pop;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        ev = '0;
        empty_pop = 1'b0;
        if (master_rd_dvld) begin
          if (q.size() > 0) begin
            t = q.pop_front();
            ev[t] = 1'b1;
          end else empty_pop = 1'b1;
        end
        check("rd_route", {backdoor_qvld, slave_rd_dvld}, ev);
        check("tag_err", tag_err, exp_tag_err);
        if (master_rd_dvld) begin
          check("slave_rd_data", slave_rd_data, master_rd_data);
          check("backdoor_q", backdoor_q, master_rd_data);
        end
        if (empty_pop) exp_tag_err = 1'b1;
      end
    end
  end

  initial begin
    drive(7);
    repeat (2) @(negedge clk);
    slave_wr_strb = '1; slave_rd_strb = '1;
    backdoor_req = 1'b1; backdoor_r = 1'b1; master_rd_dvld = 1'b1;
    #1 check_quiet("reset");
    @(negedge clk);
    drive(7);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)  cycle(0);
    for (int i = 0; i < 30; i++)  cycle(1);
    for (int i = 0; i < 20; i++)  cycle(3);
    for (int i = 0; i < 400; i++) cycle(2);
    for (int i = 0; i < 20; i++)  cycle(4);
    reset_mid();
    cycle(5);
    for (int i = 0; i < 3; i++)   cycle(7);
    for (int i = 0; i < 200; i++) cycle(2);
    for (int i = 0; i < 8; i++)   cycle(6);
    for (int i = 0; i < 2; i++)   cycle(7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
